// File: rtl/ercm_err_monitor_pkg.sv
// ---------------------------------------------------------------------------
// ercm_mon_pkg
//   Shared types and default widths for the ERCM error-statistics monitor.
//   - state_e      : window-control FSM states
//   - DEF_*        : default operand / product / counter / accumulator widths
//   - max_int()    : elaboration-time helper for sizing intermediate sums
// ---------------------------------------------------------------------------
package ercm_mon_pkg;

    localparam int DEF_DW    = 8;   // operand width
    localparam int DEF_PW    = 16;  // product width (2*DW)
    localparam int DEF_CNT_W = 16;  // sample / window counter width
    localparam int DEF_SUM_W = 32;  // ED accumulator width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : ercm_mon_pkg

// File: rtl/ercm_err_monitor_if.sv
// ---------------------------------------------------------------------------
// ercm_err_monitor_if
//   Sample stream from the approximate multiplier into the error monitor.
//   - in_vld   : sample valid (master -> slave)
//   - in_rdy   : sample ready (slave -> master); transfer on in_vld & in_rdy
//   - dat_in_a : operand A
//   - dat_in_b : operand B
//   - dat_i    : approximate product of dat_in_a * dat_in_b
// ---------------------------------------------------------------------------
interface ercm_err_monitor_if #(
    parameter int DW = 8,
    parameter int PW = 16
);
    logic          in_vld;
    logic          in_rdy;
    logic [DW-1:0] dat_in_a;
    logic [DW-1:0] dat_in_b;
    logic [PW-1:0] dat_i;

    modport master (
        output in_vld,
        output dat_in_a,
        output dat_in_b,
        output dat_i,
        input  in_rdy
    );

    modport slave (
        input  in_vld,
        input  dat_in_a,
        input  dat_in_b,
        input  dat_i,
        output in_rdy
    );
endinterface : ercm_err_monitor_if

// File: rtl/ercm_ed_calc.sv
// ---------------------------------------------------------------------------
// ercm_ed_calc
//   Two-stage error-distance pipe.
//     S1: registers the exact product a*b and the approximate product.
//     S2: registers ed = |exact - approx|.
//   Valids travel alongside the data; there is no backpressure.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   vld_i               : sample accepted this cycle
//   a_i, b_i, p_i       : operands and approximate product
//   s1_vld_o, s2_vld_o  : stage valids (S2 valid qualifies ed_o)
//   ed_o                : error distance of the sample in S2
// ---------------------------------------------------------------------------
module ercm_ed_calc
    import ercm_mon_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int PW = DEF_PW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vld_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [PW-1:0] p_i,
    output logic          s1_vld_o,
    output logic          s2_vld_o,
    output logic [PW-1:0] ed_o
);

    logic          s1_vld_q;
    logic          s2_vld_q;
    logic [PW-1:0] exact_q;
    logic [PW-1:0] approx_q;
    logic [PW-1:0] ed_q;
    logic [PW-1:0] ed_d;
    logic [PW:0]   diff;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its sources, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= vld_i;
            s2_vld_q <= s1_vld_q;
        end
    end

    // NOTE: only the valids are reset; the data registers are always
    // qualified by a valid, so resetting them would buy nothing.
    always_ff @(posedge clk) begin
        if (vld_i) begin
            exact_q  <= PW'(a_i) * PW'(b_i);
            approx_q <= p_i;
        end
        if (s1_vld_q) begin
            ed_q <= ed_d;
        end
    end

    // Difference in PW+1 bits so the sign is explicit; the magnitude is
    // always below 2^PW and fits the PW-bit result.
    always_comb begin
        diff = {1'b0, exact_q} - {1'b0, approx_q};
        ed_d = diff[PW] ? PW'(-diff) : diff[PW-1:0];
    end

    assign s1_vld_o = s1_vld_q;
    assign s2_vld_o = s2_vld_q;
    assign ed_o     = ed_q;

endmodule : ercm_ed_calc

// File: rtl/ercm_err_monitor.sv
// ---------------------------------------------------------------------------
// ercm_err_monitor
//   Error-statistics collector for the approximate 8x8 multiplier. Over a
//   window of win_len samples it counts samples, erroneous samples, the
//   saturating sum of error distance and the maximum error distance.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle pulse, starts a window (IDLE/DONE only)
//   win_len     : window length in samples, latched on an accepted start
//   smp_if      : sample stream (slave side), in_rdy high only in RUN
//   busy        : high in RUN and DRAIN
//   done        : high in DONE until the next accepted start
//   smp_cnt     : samples accumulated
//   err_cnt     : samples with nonzero error distance
//   sum_ed      : saturating sum of error distance
//   max_ed      : largest error distance seen
// Results update live while busy and are final while done is high.
// ---------------------------------------------------------------------------
module ercm_err_monitor
    import ercm_mon_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int PW    = DEF_PW,
    parameter int CNT_W = DEF_CNT_W,
    parameter int SUM_W = DEF_SUM_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   win_len,
    ercm_err_monitor_if.slave  smp_if,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   smp_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [SUM_W-1:0]   sum_ed,
    output logic [PW-1:0]      max_ed
);

    // Intermediate sum width: wide enough for either operand plus a carry.
    localparam int             SW      = max_int(SUM_W, PW) + 1;
    localparam logic [SUM_W-1:0] SUM_MAX = {SUM_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] win_len_q;
    logic [CNT_W-1:0] acc_cnt_q;
    logic [CNT_W-1:0] acc_cnt_inc;
    logic [CNT_W-1:0] smp_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [SUM_W-1:0] sum_ed_q;
    logic [SUM_W-1:0] sum_ed_d;
    logic [PW-1:0]    max_ed_q;
    logic [SW-1:0]    sum_ext;

    logic             in_rdy;
    logic             xfer;
    logic             clr;
    logic             s1_vld;
    logic             s2_vld;
    logic [PW-1:0]    ed;

    assign in_rdy      = (state_q == RUN);
    assign xfer        = smp_if.in_vld & in_rdy;
    assign acc_cnt_inc = acc_cnt_q + CNT_W'(1);

    ercm_ed_calc #(
        .DW (DW),
        .PW (PW)
    ) u_ed_calc (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld_i    (xfer),
        .a_i      (smp_if.dat_in_a),
        .b_i      (smp_if.dat_in_b),
        .p_i      (smp_if.dat_i),
        .s1_vld_o (s1_vld),
        .s2_vld_o (s2_vld),
        .ed_o     (ed)
    );

    // ------------------------------------------------------------------
    // Window-control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output is given a default before the case
    // statement, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                // start is only honoured here; a sample presented in the
                // same cycle is not taken because in_rdy is low.
                if (start) begin
                    clr     = 1'b1;
                    state_d = (win_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer && (acc_cnt_inc == win_len_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Both stages empty means the final sample has already
                // been accumulated at the previous edge.
                if (!s1_vld && !s2_vld) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Window bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_len_q <= '0;
            acc_cnt_q <= '0;
        end else if (clr) begin
            win_len_q <= win_len;
            acc_cnt_q <= '0;
        end else if (xfer) begin
            acc_cnt_q <= acc_cnt_inc;
        end
    end

    // ------------------------------------------------------------------
    // S3: accumulate
    // ------------------------------------------------------------------
    always_comb begin
        sum_ext  = SW'(sum_ed_q) + SW'(ed);
        sum_ed_d = (sum_ext > SW'(SUM_MAX)) ? SUM_MAX : sum_ext[SUM_W-1:0];
    end

    // clr and s2_vld never coincide: the pipe is empty in IDLE and DONE.
    // The counters cannot wrap since win_len bounds them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_cnt_q <= '0;
            err_cnt_q <= '0;
            sum_ed_q  <= '0;
            max_ed_q  <= '0;
        end else if (clr) begin
            smp_cnt_q <= '0;
            err_cnt_q <= '0;
            sum_ed_q  <= '0;
            max_ed_q  <= '0;
        end else if (s2_vld) begin
            smp_cnt_q <= smp_cnt_q + CNT_W'(1);
            if (ed != '0) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
            sum_ed_q <= sum_ed_d;
            if (ed > max_ed_q) begin
                max_ed_q <= ed;
            end
        end
    end

    assign smp_if.in_rdy = in_rdy;
    assign busy          = (state_q == RUN) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign smp_cnt       = smp_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign sum_ed        = sum_ed_q;
    assign max_ed        = max_ed_q;

endmodule : ercm_err_monitor
